// File: rtl/riscv_lsu.sv
// RISC-V load/store unit: turns a decoded memory instruction into a single
// data-memory access, stalls the core until memory answers, and extends
// load data to 32 bits.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   core_req_i/we_i     memory instruction present / store (1) or load (0)
//   core_size_i         access size code (B, H, W, BU, HU)
//   core_addr_i/wd_i    byte address and store data
//   core_rd_o           extended load result (combinational from mem_rd_i)
//   core_stall_o        core must hold its PC and pipeline
//   core_misalign_o     misaligned address or illegal size code
//   mem_req_o/we_o      data-memory request / write enable
//   mem_be_o            byte enables
//   mem_addr_o/wd_o     data-memory address / lane-replicated write data
//   mem_rd_i            data-memory read word
//   mem_ready_i         memory completes the access this cycle
module riscv_lsu (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        core_misalign_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t      state_q;
  logic        size_legal;
  logic        aligned;
  logic        access_ok;
  logic        req_valid;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  // Size legality and natural alignment check.
  always_comb begin
    size_legal = 1'b0;
    aligned    = 1'b1;
    case (core_size_i)
      LDST_B, LDST_BU: size_legal = 1'b1;
      LDST_H, LDST_HU: begin
        size_legal = 1'b1;
        aligned    = ~core_addr_i[0];
      end
      LDST_W: begin
        size_legal = 1'b1;
        aligned    = (core_addr_i[1:0] == 2'b00);
      end
      default: size_legal = 1'b0;
    endcase
  end

  assign access_ok = size_legal & aligned;
  assign req_valid = core_req_i & access_ok;

  // State register. A faulting request in BUSY leaves the state untouched;
  // dropping core_req_i in BUSY is a flush and abandons the access.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: if (req_valid) state_q <= BUSY;
        BUSY: begin
          if (!core_req_i)                    state_q <= IDLE;
          else if (req_valid && mem_ready_i)  state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read-lane selection feeding the load extender.
  always_comb begin
    case (core_addr_i[1:0])
      2'd0:    rd_byte = mem_rd_i[7:0];
      2'd1:    rd_byte = mem_rd_i[15:8];
      2'd2:    rd_byte = mem_rd_i[23:16];
      default: rd_byte = mem_rd_i[31:24];
    endcase
    rd_half = core_addr_i[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
  end

  // Handshake, byte enables, write replication and load extension.
  // Everything except the fault flag is forced to zero while in reset.
  always_comb begin
    mem_req_o       = 1'b0;
    core_stall_o    = 1'b0;
    mem_be_o        = 4'b0000;
    mem_wd_o        = 32'h0;
    core_rd_o       = 32'h0;
    mem_addr_o      = 32'h0;
    core_misalign_o = core_req_i & ~access_ok;

    if (!rst_i) begin
      mem_req_o    = req_valid;
      // mem_ready_i is ignored in IDLE, so the minimum stall is one cycle.
      core_stall_o = req_valid & ((state_q == IDLE) | ~mem_ready_i);
      mem_addr_o   = core_addr_i;

      if (mem_req_o) begin
        case (core_size_i)
          LDST_B, LDST_BU: mem_be_o = 4'b0001 << core_addr_i[1:0];
          LDST_H, LDST_HU: mem_be_o = core_addr_i[1] ? 4'b1100 : 4'b0011;
          LDST_W:          mem_be_o = 4'b1111;
          default:         mem_be_o = 4'b0000;
        endcase
      end

      case (core_size_i)
        LDST_B, LDST_BU: mem_wd_o = {4{core_wd_i[7:0]}};
        LDST_H, LDST_HU: mem_wd_o = {2{core_wd_i[15:0]}};
        LDST_W:          mem_wd_o = core_wd_i;
        default:         mem_wd_o = 32'h0;
      endcase

      case (core_size_i)
        LDST_B:  core_rd_o = {{24{rd_byte[7]}}, rd_byte};
        LDST_BU: core_rd_o = {24'h0, rd_byte};
        LDST_H:  core_rd_o = {{16{rd_half[15]}}, rd_half};
        LDST_HU: core_rd_o = {16'h0, rd_half};
        LDST_W:  core_rd_o = mem_rd_i;
        default: core_rd_o = 32'h0;
      endcase
    end
  end

  assign mem_we_o = mem_req_o & core_we_i;

endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu: directed vector table, hand-written
// multi-cycle sequences, then randomized traffic against a reference model.
module tb_riscv_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req;
  logic        core_we;
  logic [2:0]  core_size;
  logic [31:0] core_addr;
  logic [31:0] core_wd;
  logic [31:0] core_rd;
  logic        core_stall;
  logic        core_misalign;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic        mem_ready;

  int total = 0;
  int bad   = 0;

  riscv_lsu dut (
    .clk_i(clk), .rst_i(rst),
    .core_req_i(core_req), .core_we_i(core_we), .core_size_i(core_size),
    .core_addr_i(core_addr), .core_wd_i(core_wd), .core_rd_o(core_rd),
    .core_stall_o(core_stall), .core_misalign_o(core_misalign),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be),
    .mem_addr_o(mem_addr), .mem_wd_o(mem_wd), .mem_rd_i(mem_rd),
    .mem_ready_i(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    logic        exp_req;
    logic        exp_we;
    logic        exp_stall;
    logic        exp_mis;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[8];

  // Reference-model state: is an access outstanding?
  bit busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic req, input logic we, input logic [2:0] size,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rdata, input logic ready);
    core_req  = req;
    core_we   = we;
    core_size = size;
    core_addr = addr;
    core_wd   = wd;
    mem_rd    = rdata;
    mem_ready = ready;
  endtask

  // Behavioural expectation from the architectural rules, given current
  // inputs and whether an access is outstanding.
  task automatic model(output logic e_req, output logic e_we, output logic e_stall,
                       output logic e_mis, output logic [3:0] e_be,
                       output logic [31:0] e_addr, output logic [31:0] e_wd,
                       output logic [31:0] e_rd, output bit e_valid);
    int sz, lane;
    bit legal, align;
    logic [31:0] b, h;
    sz    = int'(core_size);
    lane  = int'(core_addr % 4);
    legal = (sz == 0 || sz == 1 || sz == 2 || sz == 4 || sz == 5);
    align = 1;
    if (sz == 1 || sz == 5) align = (core_addr % 2 == 0);
    if (sz == 2)            align = (core_addr % 4 == 0);
    e_valid = core_req && legal && align;
    e_mis   = core_req && !(legal && align);
    b = (mem_rd >> (8 * lane)) & 32'hFF;
    h = (mem_rd >> (16 * (lane / 2))) & 32'hFFFF;
    e_req = 0; e_we = 0; e_stall = 0; e_be = 0; e_addr = 0; e_wd = 0; e_rd = 0;
    if (!rst) begin
      e_req   = e_valid;
      e_we    = e_valid && core_we;
      e_stall = e_valid && (!busy || !mem_ready);
      e_addr  = core_addr;
      if (e_valid) begin
        if (sz == 0 || sz == 4) e_be = 4'(1 << lane);
        else if (sz == 1 || sz == 5) e_be = (lane >= 2) ? 4'hC : 4'h3;
        else e_be = 4'hF;
      end
      if (sz == 0 || sz == 4) e_wd = (core_wd & 32'hFF) * 32'h01010101;
      else if (sz == 1 || sz == 5) e_wd = (core_wd & 32'hFFFF) * 32'h00010001;
      else if (sz == 2) e_wd = core_wd;
      case (sz)
        0: e_rd = (b >= 128) ? (b | 32'hFFFFFF00) : b;
        4: e_rd = b;
        1: e_rd = (h >= 32768) ? (h | 32'hFFFF0000) : h;
        5: e_rd = h;
        2: e_rd = mem_rd;
        default: e_rd = 0;
      endcase
    end
  endtask

  initial begin
    logic        e_req, e_we, e_stall, e_mis;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wd, e_rd;
    bit          e_valid;
    int          stalls;

    vecs[0] = '{"lw_100",   0, 3'd2, 32'h100, 32'h0,        32'hDEADBEEF, 1, 0, 1, 0, 4'hF, 32'h0,        32'hDEADBEEF};
    vecs[1] = '{"lb_103",   0, 3'd0, 32'h103, 32'h55,       32'h80112233, 1, 0, 1, 0, 4'h8, 32'h55555555, 32'hFFFFFF80};
    vecs[2] = '{"lbu_103",  0, 3'd4, 32'h103, 32'h55,       32'h80112233, 1, 0, 1, 0, 4'h8, 32'h55555555, 32'h00000080};
    vecs[3] = '{"sh_202",   1, 3'd1, 32'h202, 32'h1234ABCD, 32'h80112233, 1, 1, 1, 0, 4'hC, 32'hABCDABCD, 32'hFFFF8011};
    vecs[4] = '{"lw_102",   0, 3'd2, 32'h102, 32'h0,        32'h11223344, 0, 0, 0, 1, 4'h0, 32'h0,        32'h11223344};
    vecs[5] = '{"sh_001",   1, 3'd1, 32'h001, 32'h1234ABCD, 32'h0000F00D, 0, 0, 0, 1, 4'h0, 32'hABCDABCD, 32'hFFFFF00D};
    vecs[6] = '{"size3",    0, 3'd3, 32'h100, 32'h77,       32'hDEADBEEF, 0, 0, 0, 1, 4'h0, 32'h0,        32'h0};
    vecs[7] = '{"lhu_002",  0, 3'd5, 32'h002, 32'h0,        32'h80010000, 1, 0, 1, 0, 4'hC, 32'h0,        32'h00008001};

    // Reset: with no request every output must be zero.
    rst = 1;
    drive(0, 1, 3'd2, 32'hCAFE_F00C, 32'h1357_9BDF, 32'hFFFF_FFFF, 1);
    tick(); tick();
    #3;
    chk("rst_rd", core_rd, 0);
    chk("rst_stall", 32'(core_stall), 0);
    chk("rst_mis", 32'(core_misalign), 0);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_be", 32'(mem_be), 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wd", mem_wd, 0);
    tick();
    rst = 0;
    tick();

    // Directed vectors, each presented in IDLE and followed by a flush.
    for (int i = 0; i < 8; i++) begin
      drive(1, vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wd, vecs[i].rdata, 1);
      #3;
      chk({vecs[i].name, "_req"},   32'(mem_req),       32'(vecs[i].exp_req));
      chk({vecs[i].name, "_we"},    32'(mem_we),        32'(vecs[i].exp_we));
      chk({vecs[i].name, "_stall"}, 32'(core_stall),    32'(vecs[i].exp_stall));
      chk({vecs[i].name, "_mis"},   32'(core_misalign), 32'(vecs[i].exp_mis));
      chk({vecs[i].name, "_be"},    32'(mem_be),        32'(vecs[i].exp_be));
      chk({vecs[i].name, "_wd"},    mem_wd,             vecs[i].exp_wd);
      chk({vecs[i].name, "_rd"},    core_rd,            vecs[i].exp_rd);
      chk({vecs[i].name, "_addr"},  mem_addr,           vecs[i].addr);
      tick();
      core_req = 0;
      tick();
    end

    // LW with memory ready in the first BUSY cycle: one stall cycle.
    drive(1, 0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    #3;
    chk("lw_idle_stall", 32'(core_stall), 1);
    tick();
    mem_ready = 1;
    #3;
    chk("lw_busy_stall", 32'(core_stall), 0);
    chk("lw_busy_req", 32'(mem_req), 1);
    chk("lw_busy_be", 32'(mem_be), 32'hF);
    chk("lw_busy_rd", core_rd, 32'hDEADBEEF);
    tick();
    // Back in IDLE: ready is ignored, a new request stalls again.
    #3;
    chk("lw_back_idle_stall", 32'(core_stall), 1);
    tick();
    core_req = 0;
    tick();

    // SH with ready delayed three BUSY cycles: stall held four cycles.
    drive(1, 1, 3'd1, 32'h202, 32'h1234ABCD, 32'h0, 0);
    stalls = 0;
    for (int c = 0; c < 5; c++) begin
      mem_ready = (c == 4);
      #3;
      if (core_stall) stalls++;
      if (c == 4) begin
        chk("sh_we", 32'(mem_we), 1);
        chk("sh_be", 32'(mem_be), 32'hC);
        chk("sh_wd", mem_wd, 32'hABCDABCD);
      end
      tick();
    end
    chk("sh_stall_cycles", stalls, 4);
    core_req = 0;
    mem_ready = 0;
    tick();

    // Reset in the second BUSY cycle, then a late response.
    drive(1, 0, 3'd2, 32'h200, 32'h0, 32'h12345678, 0);
    tick();
    tick();
    rst = 1;
    #3;
    chk("rstb_req", 32'(mem_req), 0);
    chk("rstb_stall", 32'(core_stall), 0);
    tick();
    rst = 0;
    core_req = 0;
    mem_ready = 1;
    #3;
    chk("late_rsp_req", 32'(mem_req), 0);
    chk("late_rsp_stall", 32'(core_stall), 0);
    tick();
    core_req = 1;
    #3;
    chk("after_rst_idle_stall", 32'(core_stall), 1);
    tick();
    core_req = 0;
    tick();

    // Randomized traffic against the reference model.
    rst = 1;
    busy = 0;
    tick();
    rst = 0;
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 39) == 0);
      core_req  = ($urandom_range(0, 3) != 0);
      core_we   = 1'($urandom_range(0, 1));
      core_size = 3'($urandom_range(0, 7));
      core_addr = $urandom;
      core_wd   = $urandom;
      mem_rd    = $urandom;
      mem_ready = 1'($urandom_range(0, 1));
      #3;
      model(e_req, e_we, e_stall, e_mis, e_be, e_addr, e_wd, e_rd, e_valid);
      chk("rnd_req", 32'(mem_req), 32'(e_req));
      chk("rnd_we", 32'(mem_we), 32'(e_we));
      chk("rnd_stall", 32'(core_stall), 32'(e_stall));
      chk("rnd_mis", 32'(core_misalign), 32'(e_mis));
      chk("rnd_be", 32'(mem_be), 32'(e_be));
      chk("rnd_addr", mem_addr, e_addr);
      chk("rnd_rd", core_rd, e_rd);
      if (core_size == 3'd0 || core_size == 3'd1 || core_size == 3'd2)
        chk("rnd_wd", mem_wd, e_wd);
      @(posedge clk);
      if (rst) busy = 0;
      else if (!busy) busy = e_valid;
      else if (!core_req) busy = 0;
      else if (e_valid && mem_ready) busy = 0;
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
